// File: rtl/fifo_sync.sv
// Single-clock FIFO: power-of-two depth, almost-full/empty thresholds, optional FWFT read
// port, sticky overflow/underflow. Define FIFO_EDGE_EN to turn wr_en/rd_en into rising-edge strobes.
module fifo_sync #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   afull_lvl,
    input  logic [ADDR_WIDTH:0]   aempty_lvl,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  wr_s, rd_s, wr_ok, rd_ok;

`ifdef FIFO_EDGE_EN
    // Delayed copies reset to 0, so an enable held through reset release still fires once.
    logic wr_en_d, rd_en_d;
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_d <= 1'b0;
            rd_en_d <= 1'b0;
        end else begin
            wr_en_d <= wr_en;
            rd_en_d <= rd_en;
        end
    end
    assign wr_s = wr_en & ~wr_en_d;
    assign rd_s = rd_en & ~rd_en_d;
`else
    assign wr_s = wr_en;
    assign rd_s = rd_en;
`endif

    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_L);
    assign almost_empty = (cnt <= aempty_lvl);
    assign almost_full  = (cnt >= afull_lvl);
    assign level        = cnt;

    assign wr_ok = wr_s & ~full;
    assign rd_ok = rd_s & ~empty;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + ONE_L;
                2'b01:   cnt <= cnt - ONE_L;
                default: cnt <= cnt;
            endcase
            // A new error event wins over a same-cycle clear.
            if (wr_s && full)    overflow <= 1'b1;
            else if (clr_err)    overflow <= 1'b0;
            if (rd_s && empty)   underflow <= 1'b1;
            else if (clr_err)    underflow <= 1'b0;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [1:0]            vld_pipe;
            logic [DATA_WIDTH-1:0] rd_q;
            assign vld_pipe[0] = rd_ok;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    vld_pipe[1] <= 1'b0;
                    rd_q        <= '0;
                end else begin
                    vld_pipe[1] <= vld_pipe[0];
                    if (rd_ok) rd_q <= mem[rd_ptr];
                end
            end
            assign rd_data  = rd_q;
            assign rd_valid = vld_pipe[1];
        end else begin : g_fwft
            // Head word is always presented; a pop just advances rd_ptr.
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: standard-mode instance plus an FWFT instance.
module tb_fifo_sync;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wr_data;
    logic        wr_en, rd_en, wr_en1, rd_en1, clr_err;
    logic [5:0]  afull_lvl, aempty_lvl;

    logic [15:0] rd_data, rd_data1;
    logic        rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic        rd_valid1, empty1, full1, almost_empty1, almost_full1, overflow1, underflow1;
    logic [5:0]  level, level1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .afull_lvl(afull_lvl), .aempty_lvl(aempty_lvl), .clr_err(clr_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en1), .rd_en(rd_en1),
        .afull_lvl(afull_lvl), .aempty_lvl(aempty_lvl), .clr_err(clr_err),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .empty(empty1), .full(full1),
        .almost_empty(almost_empty1), .almost_full(almost_full1), .level(level1),
        .overflow(overflow1), .underflow(underflow1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle first so edge-detected enables see a fresh rising edge.
    task automatic op(input logic w, input logic r, input logic [15:0] d);
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        wr_en = w; rd_en = r; wr_data = d;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_aempty: got %b want 1", almost_empty); end
        n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_afull: got %b want 0", almost_full); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_errs: got %b%b want 00", overflow, underflow); end
        n_cmp++; if ({empty1, rd_valid1} !== 2'b10) begin n_bad++; $display("FAIL reset_fwft: got empty=%b valid=%b want 1 0", empty1, rd_valid1); end
    endtask

    task automatic test_fwft();
        wr_data = 16'hA5A5; wr_en1 = 1'b1;
        tick();
        wr_en1 = 1'b0;
        n_cmp++; if (rd_data1 !== 16'hA5A5) begin n_bad++; $display("FAIL fwft_data: got %h want a5a5", rd_data1); end
        n_cmp++; if ({rd_valid1, empty1} !== 2'b10) begin n_bad++; $display("FAIL fwft_valid: got valid=%b empty=%b want 1 0", rd_valid1, empty1); end
        rd_en1 = 1'b1;
        tick();
        rd_en1 = 1'b0;
        n_cmp++; if ({rd_valid1, empty1} !== 2'b01) begin n_bad++; $display("FAIL fwft_pop: got valid=%b empty=%b want 0 1", rd_valid1, empty1); end
        wr_data = 16'hB0B0; wr_en1 = 1'b1; tick(); wr_en1 = 1'b0; tick();
        wr_data = 16'hC0C0; wr_en1 = 1'b1; tick(); wr_en1 = 1'b0; tick();
        n_cmp++; if (rd_data1 !== 16'hB0B0 || level1 !== 6'd2) begin n_bad++; $display("FAIL fwft_head: got %h lvl %0d want b0b0 lvl 2", rd_data1, level1); end
        rd_en1 = 1'b1; tick(); rd_en1 = 1'b0;
        n_cmp++; if (rd_data1 !== 16'hC0C0 || rd_valid1 !== 1'b1) begin n_bad++; $display("FAIL fwft_next: got %h v=%b want c0c0 v=1", rd_data1, rd_valid1); end
        rd_en1 = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 32; i++) begin
            op(1'b1, 1'b0, 16'(i));
            n_cmp++; if (level !== 6'(i)) begin n_bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i); end
            if (i == 27 || i == 28) begin
                n_cmp++; if (almost_full !== (i == 28)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, i == 28); end
            end
            if (i == 3 || i == 4) begin
                n_cmp++; if (almost_empty !== (i == 3)) begin n_bad++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, almost_empty, i == 3); end
            end
        end
        n_cmp++; if ({full, almost_full, overflow} !== 3'b110) begin n_bad++; $display("FAIL fill_full: got full=%b af=%b ovf=%b want 1 1 0", full, almost_full, overflow); end
        op(1'b1, 1'b0, 16'h0021);
        n_cmp++; if (overflow !== 1'b1 || level !== 6'd32) begin n_bad++; $display("FAIL fill_overflow: got ovf=%b lvl %0d want 1 32", overflow, level); end
    endtask

    task automatic test_full_simul();
        op(1'b1, 1'b1, 16'h0099);
        n_cmp++; if (level !== 6'd31 || full !== 1'b0) begin n_bad++; $display("FAIL full_simul_level: got %0d full=%b want 31 0", level, full); end
        n_cmp++; if (rd_data !== 16'h0001 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL full_simul_data: got %h v=%b want 0001 v=1", rd_data, rd_valid); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 2; i <= 32; i++) begin
            op(1'b0, 1'b1, 16'h0);
            n_cmp++; if (rd_data !== 16'(i) || rd_valid !== 1'b1) begin n_bad++; $display("FAIL drain[%0d]: got %h v=%b want %h v=1", i, rd_data, rd_valid, 16'(i)); end
        end
        tick();
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 16'h0020) begin n_bad++; $display("FAIL drain_hold: got %h v=%b want 0020 v=0", rd_data, rd_valid); end
        n_cmp++; if ({empty, underflow} !== 2'b10 || level !== 6'd0) begin n_bad++; $display("FAIL drain_empty: got e=%b u=%b lvl %0d want 1 0 0", empty, underflow, level); end
        op(1'b0, 1'b1, 16'h0);
        n_cmp++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 16'h0020) begin n_bad++; $display("FAIL underflow: got u=%b v=%b d=%h want 1 0 0020", underflow, rd_valid, rd_data); end
    endtask

    task automatic test_empty_simul();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL clr_underflow: got %b want 0", underflow); end
        op(1'b1, 1'b1, 16'h0055);
        n_cmp++; if (level !== 6'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL empty_simul: got lvl %0d u=%b v=%b want 1 1 0", level, underflow, rd_valid); end
        op(1'b0, 1'b1, 16'h0);
        n_cmp++; if (rd_data !== 16'h0055 || empty !== 1'b1) begin n_bad++; $display("FAIL empty_simul_read: got %h e=%b want 0055 1", rd_data, empty); end
    endtask

    task automatic test_back_to_back();
        // Pointers sit at 1; walk them to 26 so both wrap during the run.
        for (int i = 0; i < 25; i++) begin
            op(1'b1, 1'b0, 16'h0300 + 16'(i));
            op(1'b0, 1'b1, 16'h0);
            n_cmp++; if (rd_data !== 16'h0300 + 16'(i)) begin n_bad++; $display("FAIL walk[%0d]: got %h want %h", i, rd_data, 16'h0300 + 16'(i)); end
        end
        for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 16'h0100 + 16'(i));
        n_cmp++; if (level !== 6'd10) begin n_bad++; $display("FAIL b2b_prefill: got %0d want 10", level); end
        for (int i = 0; i < 5; i++) begin
            op(1'b1, 1'b1, 16'h0200 + 16'(i));
            n_cmp++; if (rd_data !== 16'h0100 + 16'(i) || level !== 6'd10) begin n_bad++; $display("FAIL b2b[%0d]: got %h lvl %0d want %h lvl 10", i, rd_data, level, 16'h0100 + 16'(i)); end
        end
        for (int i = 0; i < 10; i++) begin
            logic [15:0] exp;
            exp = (i < 5) ? 16'h0105 + 16'(i) : 16'h0200 + 16'(i - 5);
            op(1'b0, 1'b1, 16'h0);
            n_cmp++; if (rd_data !== exp) begin n_bad++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, rd_data, exp); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_err_priority();
        for (int i = 0; i < 32; i++) op(1'b1, 1'b0, 16'h0400 + 16'(i));
        op(1'b1, 1'b0, 16'hDEAD);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL prio_set: got %b want 1", overflow); end
        wr_en = 1'b0; tick();
        wr_en = 1'b1; clr_err = 1'b1; tick();
        wr_en = 1'b0; clr_err = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL prio_set_over_clr: got %b want 1", overflow); end
        for (int i = 0; i < 15; i++) op(1'b0, 1'b1, 16'h0);
        n_cmp++; if (level !== 6'd17 || rd_data !== 16'h040E) begin n_bad++; $display("FAIL prio_level: got lvl %0d d=%h want 17 040e", level, rd_data); end
        afull_lvl = 6'd17; #1;
        n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL thresh_afull17: got %b want 1", almost_full); end
        afull_lvl = 6'd18; aempty_lvl = 6'd17; #1;
        n_cmp++; if ({almost_full, almost_empty} !== 2'b01) begin n_bad++; $display("FAIL thresh_change: got af=%b ae=%b want 0 1", almost_full, almost_empty); end
        afull_lvl = 6'd28; aempty_lvl = 6'd3;
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; tick(); rst = 1'b1;
        n_cmp++; if (level !== 6'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL rst_mid_level: got %0d e=%b want 0 1", level, empty); end
        n_cmp++; if ({overflow, underflow, rd_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_flags: got o=%b u=%b v=%b want 0 0 0", overflow, underflow, rd_valid); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_data: got %h want 0000", rd_data); end
    endtask

    task automatic test_strobe();
        logic [5:0] exp;
`ifdef FIFO_EDGE_EN
        exp = 6'd1;
`else
        exp = 6'd4;
`endif
        wr_data = 16'h0777; wr_en = 1'b1;
        repeat (4) tick();
        wr_en = 1'b0; tick();
        n_cmp++; if (level !== exp) begin n_bad++; $display("FAIL strobe_hold: got %0d want %0d", level, exp); end
    endtask

    initial begin
        rst = 1'b0; wr_data = '0; wr_en = 1'b0; rd_en = 1'b0;
        wr_en1 = 1'b0; rd_en1 = 1'b0; clr_err = 1'b0;
        afull_lvl = 6'd28; aempty_lvl = 6'd3;
        test_reset();
        test_fwft();
        test_fill();
        test_full_simul();
        test_drain();
        test_empty_simul();
        test_back_to_back();
        test_err_priority();
        test_reset_mid();
        test_strobe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
